apb_master_arb: RTL and testbench

APB_MASTER_ARB -- requirements
Module: apb_master_arb

---
 rtl/apb_master_arb.sv | 165 ++++++++++++++++
 tb/tb_apb_master_arb.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arb.sv
// Two-requester round-robin arbiter in front of a single APB master port.
// Each granted request runs one SETUP/ACCESS transfer; wait states are bounded by TIMEOUT.
module apb_master_arb #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid_i,
    input  logic              req0_write_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_wdata_i,
    output logic              req0_ready_o,
    input  logic              req1_valid_i,
    input  logic              req1_write_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_wdata_i,
    output logic              req1_ready_o,
    output logic              rsp_valid_o,
    output logic              rsp_id_o,
    output logic              rsp_err_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic [DATA_W-1:0] pwdata_o,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pready_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

    state_t            state;
    state_t            state_next;
    logic              last_grant;
    logic              grant_valid;
    logic              grant_id;
    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_id;
    logic [7:0]        wait_cnt;
    logic              xfer_done;
    logic              xfer_abort;

    // Ties go to whichever requester was not served last; reset gates ready off.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (state == IDLE && !reset) begin
            if (req0_valid_i && req1_valid_i) begin
                grant_valid = 1'b1;
                grant_id    = ~last_grant;
            end else if (req0_valid_i) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (req1_valid_i) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    assign req0_ready_o = grant_valid & ~grant_id;
    assign req1_ready_o = grant_valid & grant_id;

    // A ready in the timeout cycle still counts as a normal completion.
    assign xfer_done  = (state == ACCESS) && pready_i;
    assign xfer_abort = (state == ACCESS) && !pready_i && (wait_cnt == WAIT_LIMIT);

    always_comb begin
        state_next = state;
        psel_o     = 1'b0;
        penable_o  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                psel_o     = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
                if (xfer_done || xfer_abort) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_id     <= 1'b0;
        end else if (grant_valid) begin
            last_grant <= grant_id;
            lat_id     <= grant_id;
            lat_write  <= grant_id ? req1_write_i : req0_write_i;
            lat_addr   <= grant_id ? req1_addr_i  : req0_addr_i;
            lat_wdata  <= grant_id ? req1_wdata_i : req0_wdata_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !pready_i) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Response fields only change when a pulse is issued, so they hold between pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
        end else begin
            rsp_valid_o <= xfer_done | xfer_abort;
            if (xfer_done) begin
                rsp_id_o    <= lat_id;
                rsp_err_o   <= 1'b0;
                rsp_rdata_o <= lat_write ? '0 : prdata_i;
            end else if (xfer_abort) begin
                rsp_id_o    <= lat_id;
                rsp_err_o   <= 1'b1;
                rsp_rdata_o <= '0;
            end
        end
    end

    assign pwrite_o = lat_write;
    assign paddr_o  = lat_addr;
    assign pwdata_o = lat_wdata;

endmodule

// File: tb/tb_apb_master_arb.sv
// Self-checking bench for apb_master_arb: directed and randomized transfers
// compared against a transaction-level model of arbitration and APB timing.
module tb_apb_master_arb;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req0_valid_i = 1'b0, req0_write_i = 1'b0;
    logic [ADDR_W-1:0] req0_addr_i = '0;
    logic [DATA_W-1:0] req0_wdata_i = '0;
    logic              req0_ready_o;
    logic              req1_valid_i = 1'b0, req1_write_i = 1'b0;
    logic [ADDR_W-1:0] req1_addr_i = '0;
    logic [DATA_W-1:0] req1_wdata_i = '0;
    logic              req1_ready_o;
    logic              rsp_valid_o, rsp_id_o, rsp_err_o;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic              psel_o, penable_o, pwrite_o;
    logic [ADDR_W-1:0] paddr_o;
    logic [DATA_W-1:0] pwdata_o;
    logic [DATA_W-1:0] prdata_i = '0;
    logic              pready_i = 1'b0;

    int tests_run = 0;
    int failures  = 0;
    int model_last = 1;

    always #5 clk = ~clk;

    apb_master_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid_i(req0_valid_i), .req0_write_i(req0_write_i), .req0_addr_i(req0_addr_i),
        .req0_wdata_i(req0_wdata_i), .req0_ready_o(req0_ready_o),
        .req1_valid_i(req1_valid_i), .req1_write_i(req1_write_i), .req1_addr_i(req1_addr_i),
        .req1_wdata_i(req1_wdata_i), .req1_ready_o(req1_ready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o), .rsp_err_o(rsp_err_o), .rsp_rdata_o(rsp_rdata_o),
        .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o),
        .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i)
    );

    task automatic drive_req(input int id, input logic v, input logic w,
                             input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (id == 0) begin
            req0_valid_i = v; req0_write_i = w; req0_addr_i = a; req0_wdata_i = d;
        end else begin
            req1_valid_i = v; req1_write_i = w; req1_addr_i = a; req1_wdata_i = d;
        end
    endtask

    // One complete transfer from a single requester, entered and left at a negedge in IDLE.
    // waits = ACCESS cycles with pready low before it rises (never rises if waits >= TIMEOUT).
    task automatic run_transfer(input int id, input logic wr, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] wdata, input int waits,
                                input logic [DATA_W-1:0] rdata);
        logic exp_err;
        int   n_access;
        logic [DATA_W-1:0] exp_rdata;
        exp_err   = (waits > TIMEOUT - 1);
        n_access  = exp_err ? TIMEOUT : waits + 1;
        exp_rdata = (exp_err || wr) ? '0 : rdata;
        drive_req(id, 1'b1, wr, addr, wdata);
        #1;
        tests_run++;
        if ({req1_ready_o, req0_ready_o} !== ((id == 0) ? 2'b01 : 2'b10)) begin
            failures++;
            $display("[TB] FAIL grant_ready got %b exp id %0d", {req1_ready_o, req0_ready_o}, id);
        end
        model_last = id;
        @(negedge clk);
        drive_req(id, 1'b0, ~wr, ADDR_W'($urandom), DATA_W'($urandom));
        tests_run++;
        if ({psel_o, penable_o, pwrite_o, paddr_o} !== {2'b10, wr, addr}) begin
            failures++;
            $display("[TB] FAIL setup_fields got sel %b en %b wr %b addr %h exp 1 0 %b %h",
                     psel_o, penable_o, pwrite_o, paddr_o, wr, addr);
        end
        for (int w = 0; w < n_access; w++) begin
            @(negedge clk);
            pready_i = (w == waits);
            prdata_i = (w == waits) ? rdata : DATA_W'($urandom);
            tests_run++;
            if ({psel_o, penable_o, pwrite_o, paddr_o, rsp_valid_o} !== {2'b11, wr, addr, 1'b0}) begin
                failures++;
                $display("[TB] FAIL access_fields cyc %0d got sel %b en %b wr %b addr %h rv %b exp 1 1 %b %h 0",
                         w, psel_o, penable_o, pwrite_o, paddr_o, rsp_valid_o, wr, addr);
            end
            if (wr) begin
                tests_run++;
                if (pwdata_o !== wdata) begin
                    failures++;
                    $display("[TB] FAIL access_pwdata got %h exp %h", pwdata_o, wdata);
                end
            end
        end
        @(negedge clk);
        pready_i = 1'b0;
        prdata_i = DATA_W'($urandom);
        tests_run++;
        if ({rsp_valid_o, rsp_id_o, rsp_err_o, rsp_rdata_o, psel_o, penable_o} !==
            {1'b1, 1'(id), exp_err, exp_rdata, 2'b00}) begin
            failures++;
            $display("[TB] FAIL response got v %b id %b err %b rdata %h sel %b en %b exp 1 %0d %b %h 0 0",
                     rsp_valid_o, rsp_id_o, rsp_err_o, rsp_rdata_o, psel_o, penable_o, id, exp_err, exp_rdata);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0_valid_i = 1'b1;
        pready_i = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({psel_o, penable_o, rsp_valid_o, req0_ready_o, req1_ready_o} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl got %b exp 00000",
                     {psel_o, penable_o, rsp_valid_o, req0_ready_o, req1_ready_o});
        end
        tests_run++;
        if ({rsp_rdata_o, paddr_o, pwdata_o, rsp_err_o, rsp_id_o} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_data got rdata %h addr %h wdata %h", rsp_rdata_o, paddr_o, pwdata_o);
        end
        req0_valid_i = 1'b0;
        pready_i = 1'b0;
        reset = 1'b0;
        model_last = 1;
        @(negedge clk);
        tests_run++;
        if ({psel_o, rsp_valid_o} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL post_reset_idle got sel %b rv %b exp 0 0", psel_o, rsp_valid_o);
        end
    endtask

    task automatic test_contention();
        int   q_id[$];
        int   ngrant = 0, nrsp = 0, exp_id, exp_rsp;
        drive_req(0, 1'b1, 1'b1, ADDR_W'($urandom), DATA_W'($urandom));
        drive_req(1, 1'b1, 1'b0, ADDR_W'($urandom), DATA_W'($urandom));
        pready_i = 1'b1;
        for (int c = 0; c < 60 && nrsp < 4; c++) begin
            if (rsp_valid_o) begin
                exp_rsp = (q_id.size() > 0) ? q_id.pop_front() : -1;
                nrsp++;
                tests_run++;
                if (int'(rsp_id_o) != exp_rsp) begin
                    failures++;
                    $display("[TB] FAIL contention_rsp_id got %0d exp %0d", rsp_id_o, exp_rsp);
                end
            end
            #1;
            tests_run++;
            if (req0_ready_o && req1_ready_o) begin
                failures++;
                $display("[TB] FAIL contention_dual_ready got 11 exp at most one");
            end
            if (req0_ready_o || req1_ready_o) begin
                exp_id = (model_last == 1) ? 0 : 1;
                tests_run++;
                if (int'(req1_ready_o) != exp_id) begin
                    failures++;
                    $display("[TB] FAIL contention_order grant %0d got %0d exp %0d", ngrant, req1_ready_o, exp_id);
                end
                model_last = exp_id;
                q_id.push_back(exp_id);
                ngrant++;
            end
            @(negedge clk);
            if (ngrant == 4) begin
                req0_valid_i = 1'b0;
                req1_valid_i = 1'b0;
            end
        end
        pready_i = 1'b0;
        tests_run++;
        if (nrsp != 4 || ngrant != 4) begin
            failures++;
            $display("[TB] FAIL contention_count got grants %0d rsps %0d exp 4 4", ngrant, nrsp);
        end
    endtask

    task automatic test_single_write();
        run_transfer(0, 1'b1, 10'h2A5, 32'h0000BEEF, 0, DATA_W'($urandom));
    endtask

    task automatic test_read_wait();
        run_transfer(1, 1'b0, 10'h010, DATA_W'($urandom), 3, 32'h12345678);
        @(negedge clk);
        tests_run++;
        if ({rsp_valid_o, rsp_id_o, rsp_err_o, rsp_rdata_o} !== {3'b010, 32'h12345678}) begin
            failures++;
            $display("[TB] FAIL rsp_hold got v %b id %b err %b rdata %h exp 0 1 0 12345678",
                     rsp_valid_o, rsp_id_o, rsp_err_o, rsp_rdata_o);
        end
    endtask

    task automatic test_timeout();
        run_transfer(0, 1'b0, ADDR_W'($urandom), DATA_W'($urandom), TIMEOUT + 4, DATA_W'($urandom));
        run_transfer(1, 1'b1, ADDR_W'($urandom), DATA_W'($urandom), 0, DATA_W'($urandom));
        run_transfer(0, 1'b0, ADDR_W'($urandom), DATA_W'($urandom), TIMEOUT - 1, DATA_W'($urandom));
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_transfer(int'($urandom_range(0, 1)), 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom),
                         int'($urandom_range(0, 4)), DATA_W'($urandom));
        end
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] cur_addr, exp_a, q_addr[$];
        logic [DATA_W-1:0] cur_data, exp_d, q_data[$];
        int   accepted = 0, rsps = 0, last_acc = -1;
        logic need_new = 1'b1;
        @(negedge clk);
        pready_i = 1'b1;
        exp_a = '0;
        exp_d = '0;
        for (int c = 0; c < 80 && rsps < 10; c++) begin
            if (need_new) begin
                cur_addr = ADDR_W'($urandom);
                cur_data = DATA_W'($urandom);
                need_new = 1'b0;
            end
            drive_req(0, accepted < 10, 1'b1, cur_addr, cur_data);
            if (psel_o && !penable_o) begin
                tests_run++;
                if (q_addr.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL b2b_setup got SETUP with no accepted request exp none");
                end else begin
                    exp_a = q_addr.pop_front();
                    exp_d = q_data.pop_front();
                    if ({paddr_o, pwdata_o, pwrite_o} !== {exp_a, exp_d, 1'b1}) begin
                        failures++;
                        $display("[TB] FAIL b2b_setup got addr %h data %h wr %b exp %h %h 1",
                                 paddr_o, pwdata_o, pwrite_o, exp_a, exp_d);
                    end
                end
            end
            if (psel_o && penable_o) begin
                tests_run++;
                if ({paddr_o, pwdata_o} !== {exp_a, exp_d}) begin
                    failures++;
                    $display("[TB] FAIL b2b_access got addr %h data %h exp %h %h", paddr_o, pwdata_o, exp_a, exp_d);
                end
            end
            if (rsp_valid_o) begin
                rsps++;
                tests_run++;
                if ({rsp_id_o, rsp_err_o, rsp_rdata_o} !== '0) begin
                    failures++;
                    $display("[TB] FAIL b2b_rsp got id %b err %b rdata %h exp 0 0 0", rsp_id_o, rsp_err_o, rsp_rdata_o);
                end
            end
            #1;
            if (req0_ready_o) begin
                if (last_acc >= 0) begin
                    tests_run++;
                    if (c - last_acc != 3) begin
                        failures++;
                        $display("[TB] FAIL b2b_period got %0d exp 3", c - last_acc);
                    end
                end
                last_acc = c;
                q_addr.push_back(cur_addr);
                q_data.push_back(cur_data);
                accepted++;
                need_new = 1'b1;
            end
            @(negedge clk);
        end
        req0_valid_i = 1'b0;
        pready_i = 1'b0;
        tests_run++;
        if (accepted != 10 || rsps != 10) begin
            failures++;
            $display("[TB] FAIL b2b_count got accepted %0d rsps %0d exp 10 10", accepted, rsps);
        end
    endtask

    task automatic test_reset_mid();
        int seen_rsp = 0;
        @(negedge clk);
        drive_req(1, 1'b1, 1'b0, ADDR_W'($urandom), DATA_W'($urandom));
        pready_i = 1'b0;
        @(negedge clk);
        req1_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if ({psel_o, penable_o} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL mid_pre_reset got sel %b en %b exp 1 1", psel_o, penable_o);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if ({psel_o, penable_o, rsp_valid_o} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL mid_reset_ctrl got sel %b en %b rv %b exp 0 0 0", psel_o, penable_o, rsp_valid_o);
        end
        @(negedge clk);
        reset = 1'b0;
        model_last = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid_o || psel_o) seen_rsp++;
        end
        tests_run++;
        if (seen_rsp != 0) begin
            failures++;
            $display("[TB] FAIL mid_reset_no_rsp got %0d active cycles exp 0", seen_rsp);
        end
        drive_req(0, 1'b1, 1'b0, ADDR_W'($urandom), DATA_W'($urandom));
        drive_req(1, 1'b1, 1'b0, ADDR_W'($urandom), DATA_W'($urandom));
        #1;
        tests_run++;
        if ({req1_ready_o, req0_ready_o} !== ((model_last == 1) ? 2'b01 : 2'b10)) begin
            failures++;
            $display("[TB] FAIL mid_reset_tie got %b exp 01", {req1_ready_o, req0_ready_o});
        end
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog got timeout exp completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_contention();
        test_single_write();
        test_read_wait();
        test_timeout();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
